// File: rtl/axis_dac_sink_v1_0.sv
// AXI4-Stream slave that buffers samples in a small FIFO and plays them out on a
// parallel DAC bus at a programmable tick rate. Define AXIS_DAC_OFFSET_BINARY_EN
// to emit offset-binary codes, with a mid-scale reset value, instead of two's complement.
module axis_dac_sink_v1_0 #(
  parameter int inout_width     = 16,
  parameter int fifo_depth_log2 = 4,
  parameter int rate_width      = 16,
  parameter int count_width     = 16
) (
  input  logic                       aclk,
  input  logic                       resetn,
  input  logic [inout_width-1:0]     s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       enable,
  input  logic [rate_width-1:0]      rate_div,
  input  logic                       clear_status,
  output logic [inout_width-1:0]     dac_data,
  output logic                       dac_strobe,
  output logic                       frame_end,
  output logic [fifo_depth_log2:0]   fifo_level,
  output logic                       underflow_flag,
  output logic [count_width-1:0]     underflow_count
);

  localparam int depth = 1 << fifo_depth_log2;
  localparam logic [fifo_depth_log2:0] full_level = (fifo_depth_log2+1)'(depth);

`ifdef AXIS_DAC_OFFSET_BINARY_EN
  localparam logic [inout_width-1:0] dac_reset_value = {1'b1, {(inout_width-1){1'b0}}};
`else
  localparam logic [inout_width-1:0] dac_reset_value = '0;
`endif

  logic [inout_width:0]         mem [depth];
  logic [fifo_depth_log2-1:0]   wr_ptr;
  logic [fifo_depth_log2-1:0]   rd_ptr;
  logic                         ready_en;
  logic [rate_width-1:0]        tick_cnt;
  logic                         tick;
  logic                         push;
  logic                         pop;
  logic                         underflow;
  logic [inout_width:0]         head;
  logic [inout_width-1:0]       head_code;

  // ready_en keeps tready low through reset and for the cycle after release.
  assign s_axis_tready = ready_en && (fifo_level != full_level);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign tick          = enable && (tick_cnt == rate_div);
  assign pop           = tick && (fifo_level != '0);
  assign underflow     = tick && (fifo_level == '0);
  assign head          = mem[rd_ptr];

`ifdef AXIS_DAC_OFFSET_BINARY_EN
  assign head_code = {~head[inout_width-1], head[inout_width-2:0]};
`else
  assign head_code = head[inout_width-1:0];
`endif

  // NOTE: the storage array has no reset; fifo_level alone decides what is valid.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Equality wrap means a rate_div lowered below the count runs on to rollover.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      dac_data   <= dac_reset_value;
      dac_strobe <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      dac_strobe <= pop;
      frame_end  <= pop && head[inout_width];
      if (pop) dac_data <= head_code;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      underflow_flag  <= 1'b0;
      underflow_count <= '0;
    end else if (clear_status) begin
      underflow_flag  <= 1'b0;
      underflow_count <= '0;
    end else if (underflow) begin
      underflow_flag <= 1'b1;
      if (underflow_count != '1) underflow_count <= underflow_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_dac_sink_v1_0.sv
// Self-checking bench for axis_dac_sink_v1_0: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model of the sink.
module tb_axis_dac_sink_v1_0;

  localparam int W     = 16;
  localparam int DL2   = 4;
  localparam int RW    = 16;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << DL2;
  localparam int MAXC  = (1 << CW) - 1;

`ifdef AXIS_DAC_OFFSET_BINARY_EN
  localparam logic [W-1:0] RESET_VAL = 16'h8000;
`else
  localparam logic [W-1:0] RESET_VAL = 16'h0000;
`endif

  logic          aclk = 1'b0;
  logic          resetn;
  logic [W-1:0]  tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          enable;
  logic [RW-1:0] rate_div;
  logic          clear_status;
  logic [W-1:0]  dac_data;
  logic          dac_strobe;
  logic          frame_end;
  logic [DL2:0]  fifo_level;
  logic          underflow_flag;
  logic [CW-1:0] underflow_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [W:0]    m_q [$];
  int            m_cnt;
  logic [W-1:0]  m_data;
  bit            m_strobe;
  bit            m_fe;
  bit            m_flag;
  int            m_ucount;
  bit            m_ready_en;

  axis_dac_sink_v1_0 #(
    .inout_width(W), .fifo_depth_log2(DL2), .rate_width(RW), .count_width(CW)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .enable(enable), .rate_div(rate_div),
    .clear_status(clear_status), .dac_data(dac_data), .dac_strobe(dac_strobe),
    .frame_end(frame_end), .fifo_level(fifo_level),
    .underflow_flag(underflow_flag), .underflow_count(underflow_count)
  );

  always #5 aclk = ~aclk;

  // Output code for a stored sample: offset binary is the value shifted by half scale.
  function automatic logic [W-1:0] conv(input logic [W-1:0] x);
`ifdef AXIS_DAC_OFFSET_BINARY_EN
    return W'((int'(x) + (1 << (W-1))) % (1 << W));
`else
    return x;
`endif
  endfunction

  function automatic bit exp_ready();
    return m_ready_en && (m_q.size() < DEPTH);
  endfunction

  task automatic reset_model();
    m_q.delete();
    m_cnt = 0; m_data = RESET_VAL; m_strobe = 0; m_fe = 0;
    m_flag = 0; m_ucount = 0; m_ready_en = 0;
  endtask

  task automatic idle_inputs();
    tdata = '0; tlast = 0; tvalid = 0; enable = 0; rate_div = '0; clear_status = 0;
  endtask

  // Advance one clock: predict the edge from current inputs, then sample #1 after it.
  task automatic step();
    int sz;
    bit push, tick;
    logic [W:0] e;
    sz   = m_q.size();
    push = tvalid && exp_ready();
    tick = enable && (m_cnt == int'(rate_div));
    m_cnt = !enable ? 0 : (tick ? 0 : (m_cnt + 1) % (1 << RW));
    m_strobe = 0; m_fe = 0;
    if (tick && sz > 0) begin
      e = m_q.pop_front();
      m_data = conv(e[W-1:0]); m_strobe = 1; m_fe = e[W];
    end
    if (clear_status) begin
      m_flag = 0; m_ucount = 0;
    end else if (tick && sz == 0) begin
      m_flag = 1;
      if (m_ucount < MAXC) m_ucount++;
    end
    if (push) m_q.push_back({tlast, tdata});
    @(posedge aclk); #1;
    m_ready_en = 1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    resetn = 0; idle_inputs(); reset_model();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    resetn = 1;
    step();
  endtask

  task automatic test_reset();
    @(negedge aclk);
    resetn = 0; idle_inputs(); reset_model();
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (tready !== 1'b0) begin failures++; $display("FAIL reset_tready_low: got %b want 0", tready); end
    checks++;
    if (dac_data !== RESET_VAL || dac_strobe !== 0 || frame_end !== 0 || fifo_level !== 0 ||
        underflow_flag !== 0 || underflow_count !== 0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h strobe=%b fe=%b lvl=%0d flag=%b cnt=%0d want data=%h rest 0",
               dac_data, dac_strobe, frame_end, fifo_level, underflow_flag, underflow_count, RESET_VAL);
    end
    @(negedge aclk);
    resetn = 1;
    #1;
    checks++;
    if (tready !== 1'b0) begin failures++; $display("FAIL release_tready_before_edge: got %b want 0", tready); end
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (tready !== 1'b1 || dac_strobe !== 0 || fifo_level !== 0 || dac_data !== RESET_VAL) begin
        failures++;
        $display("FAIL idle_cycle%0d: tready=%b strobe=%b lvl=%0d data=%h want 1 0 0 %h",
                 i, tready, dac_strobe, fifo_level, dac_data, RESET_VAL);
      end
    end
  endtask

  task automatic test_rate_order();
    int idx [$];
    logic [W-1:0] got [$];
    do_reset();
    tvalid = 1;
    for (int i = 1; i <= 3; i++) begin tdata = W'(i); step(); end
    tvalid = 0; enable = 1; rate_div = 4;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (dac_strobe !== m_strobe || dac_data !== m_data) begin
        failures++;
        $display("FAIL rate_cycle%0d: strobe=%b data=%h want %b %h", i, dac_strobe, dac_data, m_strobe, m_data);
      end
      if (dac_strobe === 1'b1) begin idx.push_back(i); got.push_back(dac_data); end
    end
    checks++;
    if (idx.size() != 3 || idx[0] != 4 || idx[1] != 9 || idx[2] != 14) begin
      failures++;
      $display("FAIL rate_strobe_spacing: got %0d strobes at %p want cycles 4 9 14", idx.size(), idx);
    end
    checks++;
    if (got.size() != 3 || got[0] !== conv(16'h0001) || got[1] !== conv(16'h0002) || got[2] !== conv(16'h0003)) begin
      failures++;
      $display("FAIL rate_data_order: got %p want codes of 1 2 3", got);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sent [$];
    logic [W-1:0] got  [$];
    int accepted = 0;
    do_reset();
    tvalid = 1;
    for (int i = 0; i < 24; i++) begin
      tdata = W'($urandom);
      sent.push_back(tdata);
      if (tready === 1'b1) accepted++;
      step();
    end
    checks++;
    if (accepted != DEPTH || fifo_level !== (DL2+1)'(DEPTH) || tready !== 1'b0) begin
      failures++;
      $display("FAIL full_backpressure: accepted=%0d lvl=%0d tready=%b want %0d %0d 0",
               accepted, fifo_level, tready, DEPTH, DEPTH);
    end
    enable = 1; rate_div = 0;
    step();
    checks++;
    if (tready !== 1'b1 || fifo_level !== (DL2+1)'(DEPTH-1)) begin
      failures++;
      $display("FAIL ready_after_pop: tready=%b lvl=%0d want 1 %0d", tready, fifo_level, DEPTH-1);
    end
    tvalid = 0;
    if (dac_strobe === 1'b1) got.push_back(dac_data);
    for (int i = 0; i < DEPTH + 4; i++) begin
      step();
      if (dac_strobe === 1'b1) got.push_back(dac_data);
    end
    checks++;
    if (got.size() != DEPTH) begin
      failures++; $display("FAIL drain_count: got %0d samples want %0d", got.size(), DEPTH);
    end
    for (int i = 0; i < got.size() && i < DEPTH; i++) begin
      checks++;
      if (got[i] !== conv(sent[i])) begin
        failures++; $display("FAIL drain_sample%0d: got %h want %h", i, got[i], conv(sent[i]));
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    tvalid = 1; tdata = 16'h1234; step();
    tvalid = 0; enable = 1; rate_div = 2;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dac_data !== m_data || dac_strobe !== m_strobe || underflow_flag !== m_flag ||
          int'(underflow_count) != m_ucount) begin
        failures++;
        $display("FAIL underflow_cycle%0d: data=%h strobe=%b flag=%b cnt=%0d want %h %b %b %0d",
                 i, dac_data, dac_strobe, underflow_flag, underflow_count, m_data, m_strobe, m_flag, m_ucount);
      end
    end
    checks++;
    if (dac_data !== conv(16'h1234) || underflow_flag !== 1'b1 || underflow_count !== 16'd3) begin
      failures++;
      $display("FAIL underflow_hold: data=%h flag=%b cnt=%0d want %h 1 3",
               dac_data, underflow_flag, underflow_count, conv(16'h1234));
    end
    // Clear lands on a tick that would otherwise underflow again.
    repeat (2) step();
    clear_status = 1; step(); clear_status = 0;
    checks++;
    if (underflow_flag !== 1'b0 || underflow_count !== '0) begin
      failures++;
      $display("FAIL clear_status: flag=%b cnt=%0d want 0 0", underflow_flag, underflow_count);
    end
  endtask

  task automatic test_tlast();
    int strobes = 0, fe_at = -1, fe_n = 0;
    do_reset();
    tvalid = 1;
    for (int i = 0; i < 3; i++) begin tdata = W'($urandom); tlast = (i == 2); step(); end
    tvalid = 0; tlast = 0; enable = 1; rate_div = RW'($urandom_range(0, 3));
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (frame_end !== m_fe || dac_strobe !== m_strobe) begin
        failures++;
        $display("FAIL tlast_cycle%0d: fe=%b strobe=%b want %b %b", i, frame_end, dac_strobe, m_fe, m_strobe);
      end
      if (dac_strobe === 1'b1) strobes++;
      if (frame_end === 1'b1) begin fe_n++; fe_at = strobes; end
    end
    checks++;
    if (fe_n != 1 || fe_at != 3) begin
      failures++; $display("FAIL tlast_position: pulses=%0d with_strobe=%0d want 1 3", fe_n, fe_at);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tvalid = ($urandom_range(0, 99) < 60);
      tdata  = W'($urandom);
      tlast  = ($urandom_range(0, 7) == 0);
      clear_status = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) begin
        enable = 0; rate_div = RW'($urandom_range(0, 4));
      end else if (!enable && $urandom_range(0, 9) == 0) begin
        enable = 1;
      end
      step();
      checks++;
      if (dac_data !== m_data || dac_strobe !== m_strobe || frame_end !== m_fe ||
          int'(fifo_level) != m_q.size() || tready !== exp_ready() ||
          underflow_flag !== m_flag || int'(underflow_count) != m_ucount) begin
        failures++;
        $display("FAIL random_cycle%0d: data=%h stb=%b fe=%b lvl=%0d rdy=%b flag=%b cnt=%0d want %h %b %b %0d %b %b %0d",
                 i, dac_data, dac_strobe, frame_end, fifo_level, tready, underflow_flag, underflow_count,
                 m_data, m_strobe, m_fe, m_q.size(), exp_ready(), m_flag, m_ucount);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tvalid = 1;
    for (int i = 0; i < 9; i++) begin tdata = W'($urandom); step(); end
    tvalid = 0; enable = 1; rate_div = 0;
    repeat (2) step();
    checks++;
    if (fifo_level !== 5'd7 || dac_strobe !== 1'b1) begin
      failures++; $display("FAIL pre_async_state: lvl=%0d strobe=%b want 7 1", fifo_level, dac_strobe);
    end
    #2 resetn = 0;
    #1;
    reset_model();
    checks++;
    if (dac_data !== RESET_VAL || dac_strobe !== 0 || frame_end !== 0 || fifo_level !== 0 ||
        tready !== 0 || underflow_flag !== 0 || underflow_count !== 0) begin
      failures++;
      $display("FAIL async_reset: data=%h stb=%b fe=%b lvl=%0d rdy=%b flag=%b cnt=%0d want %h 0 0 0 0 0 0",
               dac_data, dac_strobe, frame_end, fifo_level, tready, underflow_flag, underflow_count, RESET_VAL);
    end
    idle_inputs();
    @(negedge aclk);
    resetn = 1;
    step();
    checks++;
    if (fifo_level !== 0 || tready !== 1'b1 || dac_data !== RESET_VAL) begin
      failures++;
      $display("FAIL after_async_release: lvl=%0d rdy=%b data=%h want 0 1 %h", fifo_level, tready, dac_data, RESET_VAL);
    end
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    reset_model();
    test_reset();
    test_rate_order();
    test_backpressure();
    test_underflow();
    test_tlast();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_dac_sink_v1_0.md
Name: axis_dac_sink_v1_0

Overview:
- AXI4-Stream slave endpoint that drains filtered samples, e.g. from the FIR chain, into a DAC-style parallel output at a programmable sample rate.
- Small FIFO absorbs burstiness; backpressure via s_axis_tready.
- Holds the last sample on underflow and counts underflow events.
- Sits at the end of the processing chain, between the last AXIS stage and the converter interface.

Parameters:
- inout_width, 16, sample width in bits (signed, two's complement on the AXIS side)
- fifo_depth_log2, 4, FIFO depth = 2^fifo_depth_log2 entries
- rate_width, 16, width of the rate_div input and the internal tick counter
- count_width, 16, width of the underflow counter

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  inout_width  input sample
- s_axis_tlast  in  1  frame end marker, stored with the sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  high when the FIFO is not full
- enable  in  1  output playback enable
- rate_div  in  rate_width  tick period minus 1, in aclk cycles
- clear_status  in  1  synchronous clear of underflow_flag and underflow_count
- dac_data  out  inout_width  registered output sample
- dac_strobe  out  1  one-cycle pulse when dac_data updates
- frame_end  out  1  one-cycle pulse, coincident with dac_strobe, when the popped sample had tlast set
- fifo_level  out  fifo_depth_log2+1  current FIFO occupancy, 0..2^fifo_depth_log2
- underflow_flag  out  1  sticky; set when a tick occurs with the FIFO empty
- underflow_count  out  count_width  saturating count of underflow ticks

Behaviour:
- Reset (async, resetn=0): FIFO empty, fifo_level=0, tick counter=0, dac_data=0, dac_strobe=0, frame_end=0, underflow_flag=0, underflow_count=0. s_axis_tready=0 while resetn=0; it rises on the first clock edge after release.
- Write: push {tlast,tdata} when s_axis_tvalid && s_axis_tready.
- s_axis_tready = (fifo_level != 2^fifo_depth_log2). It is driven combinationally from registered level and does not depend on tvalid.
- Tick counter:
  - Runs only when enable=1. Increments each cycle; when it equals rate_div, tick=1 for that cycle and the counter returns to 0.
  - rate_div=0 gives a tick every cycle.
  - When enable=0, the counter is held at 0 and no ticks occur. The FIFO still accepts data.
  - If rate_div changes mid-count to a value below the current count, the counter keeps counting to wrap-around of rate_width, then proceeds normally.
- Pop, tick with FIFO non-empty:
  - Read the head entry.
  - On the next edge: dac_data=head data, dac_strobe=1 for one cycle, frame_end=head tlast.
  - Latency from tick to strobe is 1 cycle.
- Underflow, tick with FIFO empty:
  - dac_data holds its previous value and dac_strobe stays 0.
  - underflow_flag<=1; underflow_count increments, saturating at all-ones.
  - No write-to-output bypass: a push in the same cycle as an empty-FIFO tick still counts as underflow, and the pushed sample enters the FIFO.
- Simultaneous push and pop: fifo_level unchanged, pointers both advance. Full with a pop in the same cycle: tready is 0 that cycle (level still full), so no push.
- Pointers wrap modulo 2^fifo_depth_log2. Full/empty are distinguished by fifo_level.
- clear_status=1 clears flag and count on the next edge and takes priority over a coincident underflow.
- Arithmetic: no scaling. dac_data is the stored tdata, subject only to the optional feature.

Optional Feature:
- Macro: AXIS_DAC_OFFSET_BINARY_EN.
- Defined: dac_data is registered as offset binary, i.e. the MSB of the popped sample inverted (0x8000→0x0000, 0x0000→0x8000, 0x7FFF→0xFFFF for width 16). Reset value of dac_data is 2^(inout_width-1), mid-scale.
- Not defined: dac_data is two's complement, passed through unchanged, with reset value 0.

Test Plan:
- Reset/idle: resetn=0 then released, enable=0 → all outputs 0, s_axis_tready=1 after the first edge, fifo_level=0, no strobes for 100 cycles.
- Rate and order: push 0x0001,0x0002,0x0003, then enable=1 with rate_div=4 → dac_strobe every 5 cycles; dac_data 0x0001,0x0002,0x0003 in order; first strobe 1 cycle after the first tick.
- Full backpressure: fifo_depth_log2=4, enable=0, tvalid held high → exactly 16 accepted, tready=0, fifo_level=16. Set enable=1, rate_div=0 → tready returns 1 after the first pop; no data is lost or duplicated.
- Underflow: one sample 0x1234, rate_div=2 → first tick outputs 0x1234. The next ticks leave dac_data=0x1234 with no strobe, underflow_flag=1, underflow_count=1,2,...; clear_status → both 0 on the next edge.
- tlast: push 3 samples with tlast on the 3rd → frame_end pulses only with the 3rd dac_strobe.
- Async reset mid-operation: assert resetn low between clock edges with FIFO at 7 and strobes active → outputs go to reset values immediately (dac_data=0, or 0x8000 with AXIS_DAC_OFFSET_BINARY_EN); fifo_level=0 after release.
